spi_master_mc: RTL and testbench

Parametrised multi-slave SPI master, successor to the fixed-format SPI controller.
- Per transaction: runtime CPOL/CPHA, programmable SCLK divider, variable bit count up to DATA_WIDTH, full-duplex shift.
- Configurable chip-select setup/hold and a valid/ready command handshake.
- Sits between a register/AXI-lite front end and external SPI devices (ADCs, DACs, PLLs).

---
 rtl/spi_master_mc.sv | 218 +++++++++++++++++++++
 tb/tb_spi_master_mc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: runtime CPOL/CPHA, SCLK divider, 1..DATA_WIDTH bit words, CS setup/hold.
// Optional feature macro SPI_MASTER_MC_LSB_FIRST_EN adds a per-command lsb_first input.
module spi_master_mc #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned NUMBER_OF_SLAVES = 4,
  parameter int unsigned CLK_DIV_WIDTH    = 8,
  parameter int unsigned CS_SETUP_CYCLES  = 2,
  parameter int unsigned CS_HOLD_CYCLES   = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  output logic                                ready,
  input  logic [$clog2(NUMBER_OF_SLAVES)-1:0] slave_sel,
  input  logic [$clog2(DATA_WIDTH+1)-1:0]     bit_count,
  input  logic                                cpol,
  input  logic                                cpha,
  input  logic [CLK_DIV_WIDTH-1:0]            clk_div,
  input  logic [DATA_WIDTH-1:0]               tx_data,
  output logic [DATA_WIDTH-1:0]               rx_data,
  output logic                                rx_valid,
  output logic                                busy,
  output logic                                err,
  output logic                                mosi,
  input  logic                                miso,
  output logic                                sclk,
  output logic [NUMBER_OF_SLAVES-1:0]         ss_n
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
  ,
  input  logic                                lsb_first
`endif
);

  localparam int unsigned SEL_W  = $clog2(NUMBER_OF_SLAVES);
  localparam int unsigned BC_W   = $clog2(DATA_WIDTH+1);
  localparam int unsigned EDGE_W = BC_W + 1;
  localparam int unsigned PH_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX+1);
  localparam bit          SEL_SPARSE = (NUMBER_OF_SLAVES < (32'd1 << SEL_W));

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD, ST_DONE} state_t;

  state_t                   state_q, state_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [BC_W-1:0]          n_q, n_d;
  logic                     cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CLK_DIV_WIDTH-1:0] div_q, div_d, hp_q, hp_d;
  logic [PH_W-1:0]          ph_q, ph_d;
  logic [EDGE_W-1:0]        edge_q, edge_d;
  logic [DATA_WIDTH-1:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                     mosi_q, mosi_d, sclk_q, sclk_d, err_q, err_d;
  logic                     lsb_in, lsb_eff;

  logic                     sel_bad, accept, last_edge, leading, drive, sample;
  logic [BC_W-1:0]          bc_eff;
  logic [DATA_WIDTH-1:0]    tx_aln;

`ifdef SPI_MASTER_MC_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_in  = lsb_first;
  assign lsb_eff = lsb_q;
  assign lsb_d   = accept ? lsb_first : lsb_q;
`else
  assign lsb_in  = 1'b0;
  assign lsb_eff = 1'b0;
`endif

  function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] x);
    for (int unsigned i = 0; i < DATA_WIDTH; i++) bit_rev[i] = x[DATA_WIDTH-1-i];
  endfunction

  assign sel_bad   = SEL_SPARSE && (32'(slave_sel) >= NUMBER_OF_SLAVES);
  assign accept    = (state_q == ST_IDLE) && start && !sel_bad;
  assign last_edge = ((edge_q + EDGE_W'(1)) == {n_q, 1'b0});
  assign leading   = ~edge_q[0];
  // cpha=0 presents the first bit before any edge, so its final trailing edge must not shift again
  assign drive     = cpha_q ? leading : (~leading && !last_edge);
  assign sample    = cpha_q ? ~leading : leading;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      n_q       <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      hp_q      <= '0;
      ph_q      <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      mosi_q    <= 1'b0;
      sclk_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
      lsb_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      n_q       <= n_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      hp_q      <= hp_d;
      ph_q      <= ph_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      mosi_q    <= mosi_d;
      sclk_q    <= sclk_d;
      err_q     <= err_d;
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
      lsb_q     <= lsb_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (ph_q == '0) state_d = ST_XFER;
      ST_XFER:  if (hp_q == '0 && last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (ph_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d     = sel_q;
    n_d       = n_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    hp_d      = hp_q;
    ph_d      = ph_q;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    mosi_d    = mosi_q;
    sclk_d    = sclk_q;
    err_d     = 1'b0;
    bc_eff    = (bit_count == '0) ? BC_W'(DATA_WIDTH) : bit_count;
    // Word is left-aligned so the next bit out is always tx_sh[DATA_WIDTH-1]
    tx_aln    = lsb_in ? bit_rev(tx_data) : (tx_data << (BC_W'(DATA_WIDTH) - bc_eff));
    case (state_q)
      ST_IDLE: begin
        if (start && sel_bad) err_d = 1'b1;
        if (accept) begin
          sel_d   = slave_sel;
          n_d     = bc_eff;
          cpol_d  = cpol;
          cpha_d  = cpha;
          div_d   = clk_div;
          sclk_d  = cpol;
          ph_d    = PH_W'(CS_SETUP_CYCLES - 1);
          edge_d  = '0;
          rx_sh_d = '0;
          if (cpha) begin
            mosi_d  = 1'b0;
            tx_sh_d = tx_aln;
          end else begin
            mosi_d  = tx_aln[DATA_WIDTH-1];
            tx_sh_d = tx_aln << 1;
          end
        end
      end
      ST_SETUP: begin
        if (ph_q == '0) hp_d = div_q;
        else            ph_d = ph_q - PH_W'(1);
      end
      ST_XFER: begin
        if (hp_q == '0) begin
          hp_d   = div_q;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (drive) begin
            mosi_d  = tx_sh_q[DATA_WIDTH-1];
            tx_sh_d = tx_sh_q << 1;
          end
          if (sample) rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso};
          if (last_edge) ph_d = PH_W'(CS_HOLD_CYCLES - 1);
        end else begin
          hp_d = hp_q - CLK_DIV_WIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (ph_q == '0) begin
          mosi_d    = 1'b0;
          rx_data_d = lsb_eff ? (bit_rev(rx_sh_q) >> (BC_W'(DATA_WIDTH) - n_q)) : rx_sh_q;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready    = (state_q == ST_IDLE);
    busy     = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);
    rx_valid = (state_q == ST_DONE);
    ss_n     = '1;
    if (busy) ss_n[sel_q] = 1'b0;
  end

  assign rx_data = rx_data_q;
  assign mosi    = mosi_q;
  assign sclk    = sclk_q;
  assign err     = err_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed, table-driven bench for spi_master_mc with a small SPI slave model.
module tb_spi_master_mc;
  localparam int unsigned SETUP = 2;
  localparam int unsigned HOLD  = 2;
  localparam int NV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, cpol, cpha, miso, ready, busy, rx_valid, err, mosi, sclk;
  logic [1:0]  slave_sel;
  logic [5:0]  bit_count;
  logic [7:0]  clk_div;
  logic [31:0] tx_data, rx_data;
  logic [3:0]  ss_n;
  logic        loop, slave_miso;
  assign miso = loop ? mosi : slave_miso;

  logic        start5, ready5, busy5, rx_valid5, err5, mosi5, sclk5, miso5;
  logic [2:0]  sel5;
  logic [31:0] rx_data5;
  logic [4:0]  ss_n5;
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
  logic lsb_first;
`endif

  spi_master_mc u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .slave_sel(slave_sel),
    .bit_count(bit_count), .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .err(err), .mosi(mosi), .miso(miso),
    .sclk(sclk), .ss_n(ss_n)
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
    , .lsb_first(lsb_first)
`endif
  );

  spi_master_mc #(.NUMBER_OF_SLAVES(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .ready(ready5), .slave_sel(sel5),
    .bit_count(bit_count), .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .tx_data(tx_data),
    .rx_data(rx_data5), .rx_valid(rx_valid5), .busy(busy5), .err(err5), .mosi(mosi5), .miso(miso5),
    .sclk(sclk5), .ss_n(ss_n5)
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
    , .lsb_first(lsb_first)
`endif
  );

  typedef struct {
    int          id;
    logic        cpol, cpha, lsb, loop;
    logic [5:0]  bc;
    logic [7:0]  div;
    logic [1:0]  sel;
    logic [31:0] tx, slave_word, exp_rx, exp_mosi;
  } vec_t;

  vec_t vecs [NV];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int unsigned n, c, budget, edges, lead, trail, first_edge, done_cyc, ss_bad;
    logic prev_sclk, prev_act, act;
    logic [3:0]  ss_low;
    logic [31:0] mosi_seen, mask;
    n      = (v.bc == 0) ? 32 : v.bc;
    mask   = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    ss_low = ~(4'b0001 << v.sel);
    @(negedge clk);
    cpol = v.cpol; cpha = v.cpha; bit_count = v.bc; clk_div = v.div; slave_sel = v.sel;
    tx_data = v.tx; loop = v.loop;
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
    lsb_first = v.lsb;
`endif
    slave_miso = v.cpha ? 1'b0 : v.slave_word[n-1];
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0; lead = 0; trail = 0; first_edge = 0; done_cyc = 0; ss_bad = 0;
    mosi_seen = '0; prev_act = 1'b0; prev_sclk = v.cpol;
    budget = SETUP + 2*n*(v.div + 1) + HOLD + 8;
    for (c = 1; c <= budget && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk($sformatf("v%0d_ready_drop", v.id), ready, 1'b0);
        chk($sformatf("v%0d_busy", v.id), busy, 1'b1);
        chk($sformatf("v%0d_ss_fall", v.id), ss_n, ss_low);
        chk($sformatf("v%0d_sclk_setup", v.id), sclk, v.cpol);
      end
      act = (ss_n == ss_low);
      if (!act && ss_n != 4'hF) ss_bad++;
      if (act && prev_act && sclk !== prev_sclk) begin
        edges++;
        if (first_edge == 0) first_edge = c;
        if (sclk !== v.cpol) begin
          lead++;
          if (!v.cpha) mosi_seen = {mosi_seen[30:0], mosi};
          else if (lead <= n) slave_miso = v.slave_word[n-lead];
        end else begin
          trail++;
          if (v.cpha) mosi_seen = {mosi_seen[30:0], mosi};
          else if (trail < n) slave_miso = v.slave_word[n-1-trail];
        end
      end
      prev_act = act; prev_sclk = sclk;
      if (rx_valid) done_cyc = c;
    end
    if (done_cyc == 0) begin
      chk($sformatf("v%0d_timeout", v.id), 32'd0, 32'd1);
    end else begin
      chk($sformatf("v%0d_rx_data", v.id), rx_data, v.exp_rx);
      chk($sformatf("v%0d_done_cycle", v.id), done_cyc, 1 + SETUP + 2*n*(v.div+1) + HOLD);
      chk($sformatf("v%0d_first_edge", v.id), first_edge, 1 + SETUP + v.div + 1);
      chk($sformatf("v%0d_edges", v.id), edges, 2*n);
      chk($sformatf("v%0d_mosi_bits", v.id), mosi_seen & mask, v.exp_mosi);
      chk($sformatf("v%0d_ss_done", v.id), ss_n, 4'hF);
      chk($sformatf("v%0d_sclk_done", v.id), sclk, v.cpol);
      chk($sformatf("v%0d_busy_done", v.id), busy, 1'b0);
      chk($sformatf("v%0d_mosi_done", v.id), mosi, 1'b0);
      chk($sformatf("v%0d_ss_other", v.id), ss_bad, 0);
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", v.id), ready, 1'b1);
      chk($sformatf("v%0d_rx_valid_pulse", v.id), rx_valid, 1'b0);
      chk($sformatf("v%0d_rx_hold", v.id), rx_data, v.exp_rx);
      chk($sformatf("v%0d_sclk_idle", v.id), sclk, v.cpol);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned edges, c;
    logic prev_sclk;
    vecs[0] = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8,  8'd1,   2'd2, 32'h0000_00A5, 32'h0,         32'h0000_00A5, 32'h0000_00A5};
    vecs[1] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd16, 8'd2,   2'd0, 32'hFFFF_1234, 32'h0000_3C5A, 32'h0000_3C5A, 32'h0000_1234};
    vecs[2] = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 6'd16, 8'd2,   2'd1, 32'hFFFF_1234, 32'h0000_3C5A, 32'h0000_3C5A, 32'h0000_1234};
    vecs[3] = '{4, 1'b1, 1'b0, 1'b0, 1'b0, 6'd16, 8'd2,   2'd3, 32'hFFFF_1234, 32'h0000_3C5A, 32'h0000_3C5A, 32'h0000_1234};
    vecs[4] = '{5, 1'b1, 1'b1, 1'b0, 1'b0, 6'd16, 8'd2,   2'd2, 32'hFFFF_1234, 32'h0000_3C5A, 32'h0000_3C5A, 32'h0000_1234};
    vecs[5] = '{6, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  8'd0,   2'd3, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6] = '{7, 1'b1, 1'b1, 1'b0, 1'b1, 6'd1,  8'd3,   2'd0, 32'h0000_0001, 32'h0,         32'h0000_0001, 32'h0000_0001};
    vecs[7] = '{8, 1'b0, 1'b1, 1'b0, 1'b1, 6'd2,  8'd255, 2'd1, 32'h0000_0002, 32'h0,         32'h0000_0002, 32'h0000_0002};
    vecs[8] = '{9, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5,  8'd1,   2'd2, 32'hFFFF_FFF3, 32'h0,         32'h0000_0013, 32'h0000_0013};
    vecs[9] = '{10, 1'b0, 1'b1, 1'b0, 1'b0, 6'd31, 8'd0,  2'd1, 32'hAAAA_AAAA, 32'h1234_5678, 32'h1234_5678, 32'h2AAA_AAAA};

    reset_n = 1'b0; start = 1'b0; start5 = 1'b0; sel5 = '0; miso5 = 1'b0;
    cpol = 1'b0; cpha = 1'b0; bit_count = '0; clk_div = '0; slave_sel = '0; tx_data = '0;
    loop = 1'b0; slave_miso = 1'b0;
`ifdef SPI_MASTER_MC_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rx_data", rx_data, 32'h0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_ss_n", ss_n, 4'hF);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_xfer(vecs[i]);

    // Out-of-range select on a 5-slave instance
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sel5 = (k == 0) ? 3'd5 : 3'd7;
      start5 = 1'b1;
      @(posedge clk);
      #1 start5 = 1'b0;
      @(negedge clk);
      chk($sformatf("err%0d_pulse", k), err5, 1'b1);
      chk($sformatf("err%0d_ready", k), ready5, 1'b1);
      chk($sformatf("err%0d_ss", k), ss_n5, 5'h1F);
      chk($sformatf("err%0d_busy", k), busy5, 1'b0);
      prev_sclk = sclk5;
      @(negedge clk);
      chk($sformatf("err%0d_pulse_end", k), err5, 1'b0);
      repeat (4) @(negedge clk);
      chk($sformatf("err%0d_no_sclk", k), sclk5, prev_sclk);
      chk($sformatf("err%0d_ss_idle", k), ss_n5, 5'h1F);
      chk($sformatf("err%0d_idle_misc", k), {rx_valid5, mosi5, rx_data5 != 32'h0}, 3'b000);
    end

    // Reset at the 7th SCLK edge of a cpol=1 transfer
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b1; bit_count = 6'd8; clk_div = 8'd1; slave_sel = 2'd1;
    tx_data = 32'h5A; loop = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    @(negedge clk);
    prev_sclk = sclk;
    for (c = 0; c < 100 && edges < 7; c++) begin
      @(negedge clk);
      if (sclk !== prev_sclk) edges++;
      prev_sclk = sclk;
    end
    chk("rst_mid_edges_reached", edges, 7);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_sclk", sclk, 1'b0);
    chk("rst_mid_ss_n", ss_n, 4'hF);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ready", ready, 1'b1);
    chk("rst_mid_mosi", mosi, 1'b0);
    chk("rst_mid_rx", {rx_valid, rx_data}, 33'h0);
    repeat (2) @(negedge clk);
    chk("rst_mid_sclk_quiet", {sclk, ss_n}, 5'h0F);
    reset_n = 1'b1;
    run_xfer(vecs[0]);

`ifdef SPI_MASTER_MC_LSB_FIRST_EN
    begin
      vec_t l;
      l = '{11, 1'b0, 1'b0, 1'b1, 1'b1, 6'd8, 8'd1, 2'd0, 32'h0000_0001, 32'h0, 32'h0000_0001, 32'h0000_0080};
      run_xfer(l);
      l = '{12, 1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 8'd0, 2'd3, 32'h0000_0013, 32'h0, 32'h0000_0013, 32'h0000_0019};
      run_xfer(l);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
